// File: rtl/env_ramp_seq_if.sv
// Bundle of the envelope generator's control and status signals.
//   master: drives ena/trigger/levels/times (and loop when enabled),
//           observes env_out/busy/stage/done.
//   slave : the envelope generator itself.
// Optional: ENV_RAMP_LOOP_EN adds the 1-bit loop request.
interface env_ramp_seq_if #(
  parameter int DEPTH    = 4,
  parameter int STAGES   = 4,
  parameter int TIME_W   = 4,
  parameter int OUT_BITS = 16
);
  localparam int SW = $clog2(STAGES);

  logic                         ena;
  logic                         trigger;
  logic [DEPTH*STAGES-1:0]      levels;
  logic [TIME_W*(STAGES-1)-1:0] times;
`ifdef ENV_RAMP_LOOP_EN
  logic                         loop;
`endif
  logic [OUT_BITS-1:0]          env_out;
  logic                         busy;
  logic [SW-1:0]                stage;
  logic                         done;

`ifdef ENV_RAMP_LOOP_EN
  modport master (output ena, trigger, levels, times, loop,
                  input  env_out, busy, stage, done);
  modport slave  (input  ena, trigger, levels, times, loop,
                  output env_out, busy, stage, done);
`else
  modport master (output ena, trigger, levels, times,
                  input  env_out, busy, stage, done);
  modport slave  (input  ena, trigger, levels, times,
                  output env_out, busy, stage, done);
`endif
endinterface

// File: rtl/env_ramp_seq.sv
// Multi-breakpoint linear-ramp envelope generator.
// On a trigger edge it walks STAGES breakpoints. For each segment a serial
// restoring divider (OUT_BITS+FRAC clks) computes the per-tick slope. The
// ramp then advances on ena ticks and snaps to the exact end level.
// Ports: clk, rst (async, active high); bus (env_ramp_seq_if.slave):
//   ena, trigger, levels, times, [loop] in; env_out, busy, stage, done out.
// Optional: define ENV_RAMP_LOOP_EN to use bus.loop. When loop is high at
// final completion, the block restarts from breakpoint 0 without done.
module env_ramp_seq #(
  parameter int DEPTH    = 4,
  parameter int STAGES   = 4,
  parameter int TIME_W   = 4,
  parameter int TSCALE   = 1,
  parameter int OUT_BITS = 16,
  parameter int FRAC     = 8
) (
  input logic          clk,
  input logic          rst,
  env_ramp_seq_if.slave bus
);
  localparam int AW = OUT_BITS + FRAC;
  localparam int NW = TIME_W + $clog2(TSCALE + 1);
  localparam int SW = $clog2(STAGES);
  localparam int SH = OUT_BITS - DEPTH;
  localparam int CW = $clog2(AW + 1);

  typedef enum logic [1:0] {IDLE, PREP, RAMP} state_t;

  state_t              state;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       quo;     // dividend shifts out, quotient shifts in
  logic [NW-1:0]       rem;
  logic [NW-1:0]       divN;
  logic [NW-1:0]       cnt;
  logic [CW-1:0]       bitCnt;
  logic [OUT_BITS-1:0] sEnd;
  logic                neg;
  logic [SW-1:0]       stageR;
  logic                doneR;
  logic                trigPrev;

  logic [OUT_BITS-1:0] sLev [STAGES];
  logic [NW-1:0]       nSeg [STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_lev
    assign sLev[k] = OUT_BITS'(bus.levels[k*DEPTH +: DEPTH]) << SH;
  end
  for (genvar k = 0; k < STAGES-1; k++) begin : g_tim
    assign nSeg[k] = NW'(bus.times[k*TIME_W +: TIME_W]) * NW'(TSCALE);
  end

  logic loopReq;
`ifdef ENV_RAMP_LOOP_EN
  assign loopReq = bus.loop;
`else
  assign loopReq = 1'b0;
`endif

  logic trigEdge, segDone, lastSeg, wrap, restart;
  assign trigEdge = bus.trigger & ~trigPrev;
  assign segDone  = (state == PREP && divN == '0) ||
                    (state == RAMP && bus.ena && cnt == NW'(1));
  assign lastSeg  = (stageR == SW'(STAGES-2));
  assign wrap     = segDone & lastSeg & loopReq;
  assign restart  = trigEdge | wrap;

  // Segment about to be loaded: 0 on (re)start/loop, else the next one.
  logic [SW:0]         ldIdx;
  logic [OUT_BITS-1:0] ldStart, ldEnd, ldDiff;
  logic [NW-1:0]       ldN;
  logic                ldNeg;
  assign ldIdx = restart ? '0 : {1'b0, stageR} + 1'b1;

  always_comb begin
    ldStart = '0;
    ldEnd   = '0;
    ldN     = '0;
    for (int k = 0; k < STAGES; k++)
      if (k == int'(ldIdx)) ldStart = sLev[k];
    for (int k = 1; k < STAGES; k++)
      if (k - 1 == int'(ldIdx)) ldEnd = sLev[k];
    for (int k = 0; k < STAGES-1; k++)
      if (k == int'(ldIdx)) ldN = nSeg[k];
  end
  assign ldNeg  = ldEnd < ldStart;
  assign ldDiff = ldNeg ? ldStart - ldEnd : ldEnd - ldStart;

  // One restoring-division step.
  logic [NW:0] trial;
  logic        qBit;
  assign trial = {rem, quo[AW-1]};
  assign qBit  = trial >= {1'b0, divN};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      quo      <= '0;
      rem      <= '0;
      divN     <= '0;
      cnt      <= '0;
      bitCnt   <= '0;
      sEnd     <= '0;
      neg      <= 1'b0;
      stageR   <= '0;
      doneR    <= 1'b0;
      trigPrev <= 1'b0;
    end else begin
      trigPrev <= bus.trigger;
      doneR    <= 1'b0;
      if (restart || (segDone && !lastSeg)) begin
        // Enter PREP for a fresh segment; divider is loaded here so PREP
        // spends exactly AW clks iterating.
        acc    <= restart ? AW'(ldStart) << FRAC : AW'(sEnd) << FRAC;
        stageR <= restart ? '0 : stageR + 1'b1;
        state  <= PREP;
        sEnd   <= ldEnd;
        neg    <= ldNeg;
        divN   <= ldN;
        quo    <= AW'(ldDiff) << FRAC;
        rem    <= '0;
        bitCnt <= '0;
      end else if (segDone) begin
        acc   <= AW'(sEnd) << FRAC;
        state <= IDLE;
        doneR <= 1'b1;
      end else begin
        case (state)
          PREP: begin
            rem    <= qBit ? NW'(trial - {1'b0, divN}) : trial[NW-1:0];
            quo    <= {quo[AW-2:0], qBit};
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == CW'(AW-1)) begin
              state <= RAMP;
              cnt   <= divN;
            end
          end
          RAMP: if (bus.ena) begin
            // Truncated slope never overshoots; the final tick snaps.
            acc <= neg ? acc - quo : acc + quo;
            cnt <= cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.env_out = acc[AW-1 -: OUT_BITS];
  assign bus.busy    = (state != IDLE);
  assign bus.stage   = stageR;
  assign bus.done    = doneR;
endmodule

// File: tb/tb_env_ramp_seq.sv
module tb_env_ramp_seq;
  localparam int DEPTH = 4, STAGES = 3, TIME_W = 4, TSCALE = 1;
  localparam int OUT_BITS = 8, FRAC = 8;

  typedef struct {
    logic [7:0] env;
    logic       busy;
    logic       done;
    logic [1:0] stg;
    bit         chkStg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  string tname = "reset";
  exp_t sb[$];

  env_ramp_seq_if #(.DEPTH(DEPTH), .STAGES(STAGES), .TIME_W(TIME_W),
                    .OUT_BITS(OUT_BITS)) bus ();

  env_ramp_seq #(.DEPTH(DEPTH), .STAGES(STAGES), .TIME_W(TIME_W),
                 .TSCALE(TSCALE), .OUT_BITS(OUT_BITS), .FRAC(FRAC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void push(input logic [7:0] env, input logic busy,
                               input logic done, input logic [1:0] stg,
                               input bit chk);
    exp_t e;
    e.env = env; e.busy = busy; e.done = done; e.stg = stg; e.chkStg = chk;
    sb.push_back(e);
  endfunction

  // Start clk of a segment followed by its 16 divider clks, value held.
  function automatic void pushPrep(input logic [7:0] env, input logic [1:0] stg);
    push(env, 1'b1, 1'b0, stg, 1'b1);
    for (int i = 0; i < 16; i++) push(env, 1'b1, 1'b0, stg, 1'b1);
  endfunction

  function automatic void pushRampUp();
    push(8'd60,  1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd120, 1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd180, 1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd240, 1'b1, 1'b0, 2'd1, 1'b1);
  endfunction

  function automatic void pushDone();
    push(8'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    push(8'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction

  task automatic check();
    exp_t e;
    total++;
    assert (sb.size() != 0)
      else begin bad++; $error("FAIL %s sb_underflow got=0 exp=1", tname); end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (bus.env_out === e.env)
        else begin bad++; $error("FAIL %s c%0d env_out got=%0d exp=%0d", tname, cyc, bus.env_out, e.env); end
      total++;
      assert (bus.busy === e.busy)
        else begin bad++; $error("FAIL %s c%0d busy got=%0d exp=%0d", tname, cyc, bus.busy, e.busy); end
      total++;
      assert (bus.done === e.done)
        else begin bad++; $error("FAIL %s c%0d done got=%0d exp=%0d", tname, cyc, bus.done, e.done); end
      if (e.chkStg) begin
        total++;
        assert (bus.stage === e.stg)
          else begin bad++; $error("FAIL %s c%0d stage got=%0d exp=%0d", tname, cyc, bus.stage, e.stg); end
      end
    end
    cyc++;
  endtask

  task automatic tick(input logic en);
    bus.ena = en;
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) tick(en);
  endtask

  task automatic trig(input logic en);
    bus.trigger = 1'b1;
    tick(en);
    bus.trigger = 1'b0;
  endtask

  task automatic startTest(input string n);
    tname = n;
    cyc   = 0;
    total++;
    assert (sb.size() == 0)
      else begin bad++; $error("FAIL %s leftover got=%0d exp=0", n, sb.size()); end
  endtask

  initial begin
    rst         = 1'b1;
    bus.ena     = 1'b0;
    bus.trigger = 1'b0;
    bus.levels  = {4'd0, 4'd15, 4'd0};
    bus.times   = {4'd0, 4'd4};
`ifdef ENV_RAMP_LOOP_EN
    bus.loop    = 1'b0;
`endif
    @(posedge clk); #1;
    push(8'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check();
    @(negedge clk) rst = 1'b0;

    // Rising ramp 0->240 over 4 ticks, then zero-length drop to 0.
    startTest("ramp_up");
    pushPrep(8'd0, 2'd0); pushRampUp(); pushDone();
    trig(1'b1); run(22, 1'b1);

    // Flat 240 for one tick, then 240->0 over 3 ticks (step -80).
    startTest("ramp_down");
    bus.levels = {4'd0, 4'd15, 4'd15};
    bus.times  = {4'd3, 4'd1};
    pushPrep(8'd240, 2'd0);
    push(8'd240, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 16; i++) push(8'd240, 1'b1, 1'b0, 2'd1, 1'b1);
    push(8'd160, 1'b1, 1'b0, 2'd1, 1'b1);
    push(8'd80,  1'b1, 1'b0, 2'd1, 1'b1);
    pushDone();
    trig(1'b1); run(37, 1'b1);

    // ena 1 clk in 4: PREP runs with ena low; ramp values held 4 clks.
    startTest("ena_gate");
    bus.levels = {4'd0, 4'd15, 4'd0};
    bus.times  = {4'd0, 4'd4};
    pushPrep(8'd0, 2'd0);
    for (int i = 0; i < 4; i++) push(8'd60,  1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) push(8'd120, 1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) push(8'd180, 1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd240, 1'b1, 1'b0, 2'd1, 1'b1);
    pushDone();
    trig(1'b0); run(16, 1'b0);
    for (int j = 0; j < 3; j++) begin tick(1'b1); run(3, 1'b0); end
    tick(1'b1); run(2, 1'b0);

    // Retrigger at env_out=120: hard restart, full pass, single done.
    startTest("retrig_ramp");
    pushPrep(8'd0, 2'd0);
    push(8'd60,  1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd120, 1'b1, 1'b0, 2'd0, 1'b1);
    pushPrep(8'd0, 2'd0); pushRampUp(); pushDone();
    trig(1'b1); run(18, 1'b1);
    trig(1'b1); run(22, 1'b1);

    // Trigger edge on the completion clk wins over done.
    startTest("retrig_done");
    pushPrep(8'd0, 2'd0); pushRampUp();
    pushPrep(8'd0, 2'd0); pushRampUp(); pushDone();
    trig(1'b1); run(20, 1'b1);
    trig(1'b1); run(22, 1'b1);

    // Async reset between edges mid-ramp, then a normal restart.
    startTest("async_rst");
    pushPrep(8'd0, 2'd0);
    push(8'd60,  1'b1, 1'b0, 2'd0, 1'b1);
    push(8'd120, 1'b1, 1'b0, 2'd0, 1'b1);
    trig(1'b1); run(18, 1'b1);
    #3 rst = 1'b1;
    #1 push(8'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check();
    #1 rst = 1'b0;
    pushPrep(8'd0, 2'd0); pushRampUp(); pushDone();
    trig(1'b1); run(22, 1'b1);

`ifdef ENV_RAMP_LOOP_EN
    // Loop repeats the pass without done; dropping loop ends after a pass.
    startTest("loop");
    bus.loop = 1'b1;
    pushPrep(8'd0, 2'd0); pushRampUp();
    pushPrep(8'd0, 2'd0); pushRampUp(); pushDone();
    trig(1'b1); run(20, 1'b1);
    run(21, 1'b1);
    bus.loop = 1'b0;
    run(2, 1'b1);
`endif

    startTest("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
